type_unswitch_module: RTL and testbench
=======================================

Name: type_unswitch_module

Overview:
- Return-path counterpart of the type switch stage.
- At issue time it records, per transaction, whether the two BufferRAMTEFsizeInputs operands were swapped onto the ALU ports.
- When the ALU results return, in issue order and with arbitrary latency, it undoes that swap so each result lands on its original port.
- Sits between the FHE ALU result ports and the buffer RAM write-back.

Parameters:
- TAG_DEPTH, 16: tag FIFO entries. Power of 2, >= 2.
- PTR_W, $clog2(TAG_DEPTH): FIFO pointer width. Derived; do not override.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- issue_valid  input  1  transaction issued to ALU this cycle; push tag
- issue_switch  input  1  switch_set value used for that transaction
- ret_valid  input  1  ALU result pair valid this cycle; pop tag
- ret_port_0  input  BufferRAMTEFsizeInputs  ALU result, port 0
- ret_port_1  input  BufferRAMTEFsizeInputs  ALU result, port 1
- o_valid  output  1  write-back pair valid
- o_port_0  output  BufferRAMTEFsizeInputs  result for original operand 0
- o_port_1  output  BufferRAMTEFsizeInputs  result for original operand 1
- tag_full  output  1  FIFO holds TAG_DEPTH entries
- tag_empty  output  1  FIFO holds 0 entries
- err_overflow  output  1  sticky: push attempted while full
- err_underflow  output  1  sticky: ret_valid while FIFO empty

Behaviour:
- Reset (async, rst_n low):
  - o_valid=0, o_port_0=0, o_port_1=0.
  - FIFO pointers and count = 0, so tag_empty=1 and tag_full=0.
  - err_overflow=0, err_underflow=0.
  - Reset mid-operation discards all queued tags and any in-flight output.
- Tag FIFO: 1-bit entries, count register of width PTR_W+1.
  - Push when issue_valid && !tag_full.
  - Pop when ret_valid && !tag_empty.
  - Pointers wrap modulo TAG_DEPTH.
- Swap decision: uses the head tag combinationally in the cycle ret_valid is high (first-word-fall-through read).
  - tag=0: o_port_0<=ret_port_0, o_port_1<=ret_port_1.
  - tag=1: o_port_0<=ret_port_1, o_port_1<=ret_port_0.
- Latency: exactly 1 cycle, ret_valid at cycle N gives o_valid at N+1.
  - o_valid <= ret_valid every cycle.
  - Data registers hold their value when ret_valid=0.
  - No backpressure: write-back always accepts.
- Simultaneous push and pop:
  - When neither full nor empty: both happen, count unchanged.
  - When full: pop happens, push is dropped, err_overflow set. A push is never accepted on a full FIFO even with a concurrent pop.
  - When empty: push happens. Pop is not satisfied by the same-cycle push; the result passes unswapped and err_underflow is set.
- Overflow: push dropped, FIFO unchanged, err_overflow=1 until reset.
- Underflow: ret_valid with tag_empty=1 gives o_valid=1 with unswapped data, err_underflow=1 until reset, pointers unchanged.
- tag_full and tag_empty are decoded from the count register (registered state, not from same-cycle inputs).

Optional Feature:
- Macro: TYPE_UNSWITCH_STATS_EN.
- With the macro defined:
  - Adds outputs swap_cnt[31:0] and pass_cnt[31:0].
  - Each cycle with ret_valid && !tag_empty increments swap_cnt if the popped tag is 1, otherwise pass_cnt.
  - Underflow returns count in neither.
  - Both reset to 0 and wrap at 2^32.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- BufferRAMTEFsizeInputs comes from FHE_ALU_PKG.
- Add TYPE_SWITCH_TAG_DEPTH_DEFAULT (16) to FHE_ALU_PKG so the issue side and this block agree on depth.
- One sub-module is natural: tag_fifo (1-bit wide, parameterised depth, FWFT read, full/empty/count). It is reusable for other in-order sideband tracking.

Test Plan:
- Reset then idle:
  - Required: o_valid=0, ports=0, tag_empty=1, both error flags 0.
- Push tags 0,1,1,0; later four returns with port0=A+i, port1=B+i:
  - Required outputs one cycle after each return: (A0,B0), (B1,A1), (B2,A2), (A3,B3).
  - Required: tag_empty=1 afterwards.
- Fill 16 tags, then push a 17th with issue_switch=1:
  - Required: tag_full=1, err_overflow=1, and the 16 returns use the original 16 tags.
- At count 16, assert issue_valid and ret_valid in the same cycle:
  - Required: pop occurs, push dropped, count 15, err_overflow=1.
- At count 3, assert issue_valid and ret_valid in the same cycle:
  - Required: count stays 3, correct head tag used.
- ret_valid with an empty FIFO:
  - Required: unswapped output next cycle, err_underflow=1.
  - Required: a subsequent push/return still works correctly.
- Assert rst_n low with 5 tags queued and o_valid=1:
  - Required: immediately o_valid=0 and tag_empty=1.
- With TYPE_UNSWITCH_STATS_EN, tags 1,0,1 returned:
  - Required: swap_cnt=2, pass_cnt=1.

Source files
------------

// File: rtl/FHE_ALU_PKG.sv
// Shared FHE ALU types: buffer RAM operand width and the type-switch tag depth
// that the issue side and the return-path unswitch stage must agree on.
package FHE_ALU_PKG;

    localparam int BUF_RAM_W = 64;

    typedef logic [BUF_RAM_W-1:0] BufferRAMTEFsizeInputs;

    localparam int TYPE_SWITCH_TAG_DEPTH_DEFAULT = 16;

    // Route the result pair back to its original ports when the operands were swapped at issue.
    function automatic BufferRAMTEFsizeInputs pick_port(
        input logic                  swap,
        input BufferRAMTEFsizeInputs straight,
        input BufferRAMTEFsizeInputs crossed
    );
        return swap ? crossed : straight;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// 1-bit wide first-word-fall-through FIFO for in-order sideband tracking.
// Power-of-2 depth; full/empty decoded from a registered occupancy count.
module tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push on a full FIFO is refused even when a pop frees a slot the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/type_unswitch_module.sv
// Return-path type unswitch: undoes the issue-time operand swap on ALU results.
// Optional result statistics (swap_cnt/pass_cnt) under TYPE_UNSWITCH_STATS_EN.
module type_unswitch_module
    import FHE_ALU_PKG::*;
#(
    parameter int TAG_DEPTH = TYPE_SWITCH_TAG_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic                  issue_switch,
    input  logic                  ret_valid,
    input  BufferRAMTEFsizeInputs ret_port_0,
    input  BufferRAMTEFsizeInputs ret_port_1,
    output logic                  o_valid,
    output BufferRAMTEFsizeInputs o_port_0,
    output BufferRAMTEFsizeInputs o_port_1,
    output logic                  tag_full,
    output logic                  tag_empty,
    output logic                  err_overflow,
    output logic                  err_underflow
`ifdef TYPE_UNSWITCH_STATS_EN
    ,
    output logic [31:0]           swap_cnt,
    output logic [31:0]           pass_cnt
`endif
);

    logic head_tag;
    logic swap;
    logic tag_pop;

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue_valid),
        .din   (issue_switch),
        .pop   (ret_valid),
        .head  (head_tag),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // An underflowing return has no tag to honour, so it passes straight through.
    assign tag_pop = ret_valid && !tag_empty;
    assign swap    = tag_pop && head_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid       <= 1'b0;
            o_port_0      <= '0;
            o_port_1      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            o_valid <= ret_valid;
            if (ret_valid) begin
                o_port_0 <= pick_port(swap, ret_port_0, ret_port_1);
                o_port_1 <= pick_port(swap, ret_port_1, ret_port_0);
            end
            if (issue_valid && tag_full) begin
                err_overflow <= 1'b1;
            end
            if (ret_valid && tag_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef TYPE_UNSWITCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_cnt <= '0;
            pass_cnt <= '0;
        end else if (tag_pop) begin
            if (head_tag) begin
                swap_cnt <= swap_cnt + 32'd1;
            end else begin
                pass_cnt <= pass_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_type_unswitch_module.sv
// Directed bench for type_unswitch_module: swap/unswap, full/empty boundaries,
// overflow/underflow, async reset and (with TYPE_UNSWITCH_STATS_EN) statistics.
module tb_type_unswitch_module;
    import FHE_ALU_PKG::*;

    logic                  clk;
    logic                  rst_n;
    logic                  issue_valid;
    logic                  issue_switch;
    logic                  ret_valid;
    BufferRAMTEFsizeInputs ret_port_0;
    BufferRAMTEFsizeInputs ret_port_1;
    logic                  o_valid;
    BufferRAMTEFsizeInputs o_port_0;
    BufferRAMTEFsizeInputs o_port_1;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  err_overflow;
    logic                  err_underflow;
`ifdef TYPE_UNSWITCH_STATS_EN
    logic [31:0]           swap_cnt;
    logic [31:0]           pass_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    type_unswitch_module dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_switch  (issue_switch),
        .ret_valid     (ret_valid),
        .ret_port_0    (ret_port_0),
        .ret_port_1    (ret_port_1),
        .o_valid       (o_valid),
        .o_port_0      (o_port_0),
        .o_port_1      (o_port_1),
        .tag_full      (tag_full),
        .tag_empty     (tag_empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`ifdef TYPE_UNSWITCH_STATS_EN
        ,
        .swap_cnt      (swap_cnt),
        .pass_cnt      (pass_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs from a negedge; returns at the following negedge.
    task automatic step(input logic iv, input logic isw, input logic rv,
                        input BufferRAMTEFsizeInputs p0, input BufferRAMTEFsizeInputs p1);
        issue_valid  = iv;
        issue_switch = isw;
        ret_valid    = rv;
        ret_port_0   = p0;
        ret_port_1   = p1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic BufferRAMTEFsizeInputs da(input int i);
        return 64'hA000_0000_0000_0000 + 64'(i);
    endfunction

    function automatic BufferRAMTEFsizeInputs db(input int i);
        return 64'hB000_0000_0000_0000 + 64'(i);
    endfunction

    // Return pair i and check it comes back with the given swap applied.
    task automatic ret_check(input string tag, input int i, input logic sw);
        step(1'b0, 1'b0, 1'b1, da(i), db(i));
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_p0"}, o_port_0, sw ? db(i) : da(i));
        check({tag, "_p1"}, o_port_1, sw ? da(i) : db(i));
    endtask

    logic [3:0]  pat4;
    logic [15:0] fill;
    logic [2:0]  pat3;

    initial begin
        rst_n        = 1'b0;
        issue_valid  = 1'b0;
        issue_switch = 1'b0;
        ret_valid    = 1'b0;
        ret_port_0   = '0;
        ret_port_1   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Reset then idle
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_p0", o_port_0, 64'd0);
        check("rst_p1", o_port_1, 64'd0);
        check("rst_empty", 64'(tag_empty), 64'd1);
        check("rst_full", 64'(tag_full), 64'd0);
        check("rst_ovf", 64'(err_overflow), 64'd0);
        check("rst_unf", 64'(err_underflow), 64'd0);

        // Tags 0,1,1,0 then four returns
        pat4 = 4'b0110;
        for (int i = 0; i < 4; i++) step(1'b1, pat4[i], 1'b0, '0, '0);
        idle();
        check("q4_empty_before", 64'(tag_empty), 64'd0);
        for (int i = 0; i < 4; i++) ret_check("q4", i, pat4[i]);
        idle();
        check("q4_valid_drop", 64'(o_valid), 64'd0);
        check("q4_hold_p0", o_port_0, da(3));
        check("q4_empty_after", 64'(tag_empty), 64'd1);
        check("q4_no_unf", 64'(err_underflow), 64'd0);

        // Fill to 16, then overflow push with switch=1
        fill = 16'hA5C3;
        for (int i = 0; i < 16; i++) step(1'b1, fill[i], 1'b0, '0, '0);
        check("fill_full", 64'(tag_full), 64'd1);
        check("fill_ovf_clear", 64'(err_overflow), 64'd0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        check("ovf_full", 64'(tag_full), 64'd1);
        check("ovf_flag", 64'(err_overflow), 64'd1);

        // Push+pop at count 16: pop only, push dropped
        step(1'b1, 1'b1, 1'b1, da(0), db(0));
        check("fullpp_p0", o_port_0, fill[0] ? db(0) : da(0));
        check("fullpp_p1", o_port_1, fill[0] ? da(0) : db(0));
        check("fullpp_notfull", 64'(tag_full), 64'd0);
        check("fullpp_ovf", 64'(err_overflow), 64'd1);
        for (int i = 1; i < 16; i++) ret_check("drain16", i, fill[i]);
        idle();
        check("drain16_empty", 64'(tag_empty), 64'd1);
        check("drain16_no_unf", 64'(err_underflow), 64'd0);

        // Push+pop at count 3: count stays 3, head tag used
        pat3 = 3'b101;
        for (int i = 0; i < 3; i++) step(1'b1, pat3[i], 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b1, da(20), db(20));
        check("c3pp_p0", o_port_0, db(20));
        check("c3pp_p1", o_port_1, da(20));
        ret_check("c3_r1", 21, 1'b0);
        ret_check("c3_r2", 22, 1'b1);
        check("c3_not_empty", 64'(tag_empty), 64'd0);
        ret_check("c3_r3", 23, 1'b0);
        idle();
        check("c3_empty", 64'(tag_empty), 64'd1);
        check("c3_no_unf", 64'(err_underflow), 64'd0);

        // Underflow: unswapped, sticky flag, recovery
        ret_check("unf", 30, 1'b0);
        check("unf_flag", 64'(err_underflow), 64'd1);
        check("unf_empty", 64'(tag_empty), 64'd1);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        ret_check("unf_recover", 31, 1'b1);
        idle();
        check("unf_recover_empty", 64'(tag_empty), 64'd1);
        check("unf_sticky", 64'(err_underflow), 64'd1);

        // Push on empty with concurrent return: unswapped, push kept
        step(1'b1, 1'b1, 1'b1, da(32), db(32));
        check("emptypp_p0", o_port_0, da(32));
        check("emptypp_not_empty", 64'(tag_empty), 64'd0);
        ret_check("emptypp_pop", 33, 1'b1);

        // Mid-operation reset with 5 tags queued and o_valid high
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0, '0);
        ret_check("pre_rst", 40, 1'b1);
        issue_valid = 1'b0;
        ret_valid   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_empty", 64'(tag_empty), 64'd1);
        check("arst_p0", o_port_0, 64'd0);
        check("arst_ovf", 64'(err_overflow), 64'd0);
        check("arst_unf", 64'(err_underflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0, '0);
        ret_check("post_rst", 41, 1'b0);
        idle();
        check("post_rst_empty", 64'(tag_empty), 64'd1);

`ifdef TYPE_UNSWITCH_STATS_EN
        // Statistics: counters start from the reset above (post_rst counted one pass)
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        ret_check("st_r0", 50, 1'b1);
        ret_check("st_r1", 51, 1'b0);
        ret_check("st_r2", 52, 1'b1);
        ret_check("st_unf", 53, 1'b0);
        check("stats_swap", 64'(swap_cnt), 64'd2);
        check("stats_pass", 64'(pass_cnt), 64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
